// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and master IDs for the arbiter slice
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  // Beats still to come after the NONSEQ of a fixed-length burst.
  function automatic logic [4:0] burst_beats_left(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats_left = 5'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats_left = 5'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_beats_left = 5'd15;
      default:                      burst_beats_left = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_burst_tracker.sv
// rtl/ahb_arb_burst_tracker.sv - burst-length decode and hold counter for the arbiter
module ahb_arb_burst_tracker
  import ahb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hready_i,
  input  logic       hresp_i,
  input  logic [1:0] htrans_i,
  input  logic [2:0] hburst_i,
  input  logic       owner_change_i,
  output logic       burst_end_o
);

  localparam logic [4:0] HOLD_MAX  = 5'(MAX_HOLD);
  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  logic [4:0] beats_left_q, beats_left_d;
  logic [4:0] hold_cnt_q, hold_cnt_d;
  logic       xfer;

  assign xfer = (htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ);

  always_comb begin
    beats_left_d = beats_left_q;
    hold_cnt_d   = hold_cnt_q;
    if (hresp_i)
      beats_left_d = 5'd0;
    else if (htrans_i == HTRANS_NONSEQ)
      beats_left_d = burst_beats_left(hburst_i);
    else if (htrans_i == HTRANS_SEQ && beats_left_q != 5'd0)
      beats_left_d = beats_left_q - 5'd1;
    if (owner_change_i)
      hold_cnt_d = 5'd0;
    else if (xfer && hold_cnt_q < HOLD_MAX)
      hold_cnt_d = hold_cnt_q + 5'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beats_left_q <= 5'd0;
      hold_cnt_q   <= 5'd0;
    end else if (hready_i) begin
      beats_left_q <= beats_left_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Last beat of a fixed burst, or an INCR burst that has used up its hold budget.
  assign burst_end_o = (htrans_i == HTRANS_NONSEQ && hburst_i == HBURST_SINGLE) ||
                       (htrans_i == HTRANS_SEQ && beats_left_q == 5'd1) ||
                       (hburst_i == HBURST_INCR && hold_cnt_q >= HOLD_LAST);

endmodule

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - two-master (CPU/DMA) AHB arbiter with zero-cycle handover
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req_cpu,
  input  logic       req_dma,
  input  logic       lock_cpu,
  input  logic       lock_dma,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  input  logic       HRESP,
  output logic       HMASTER,
  output logic       HMASTER_DATA,
  output logic       grant_cpu,
  output logic       grant_dma,
  output logic       HMASTLOCK
);

  localparam logic DEF_MST = (DEFAULT_MASTER != 0);

  logic hmaster_q, hmaster_d;
  logic hmaster_data_q;
  logic last_owner_q, last_owner_d;
  logic owner_lock, xfer, burst_end, arb_point, owner_change, rr_last, pick;

  ahb_arb_burst_tracker #(.MAX_HOLD(MAX_HOLD)) u_tracker (
    .clk_i          (HCLK),
    .rst_ni         (HRESETn),
    .hready_i       (HREADY),
    .hresp_i        (HRESP),
    .htrans_i       (HTRANS),
    .hburst_i       (HBURST),
    .owner_change_i (owner_change),
    .burst_end_o    (burst_end)
  );

  assign owner_lock = hmaster_q ? lock_dma : lock_cpu;
  assign xfer       = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign arb_point  = HREADY && !owner_lock &&
                      (HRESP || (HTRANS != HTRANS_BUSY &&
                                 (HTRANS == HTRANS_IDLE || burst_end)));

  // A beat moving data on this edge makes the current owner the most recent user.
  assign rr_last = xfer ? hmaster_q : last_owner_q;

  always_comb begin
    pick = DEF_MST;
    case ({req_cpu, req_dma})
      2'b10:   pick = MST_CPU;
      2'b01:   pick = MST_DMA;
      2'b11:   pick = ~rr_last;
      default: pick = DEF_MST;
    endcase
  end

  assign hmaster_d    = arb_point ? pick : hmaster_q;
  assign owner_change = (hmaster_d != hmaster_q);
  assign last_owner_d = (xfer || owner_change) ? hmaster_q : last_owner_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hmaster_q      <= DEF_MST;
      hmaster_data_q <= DEF_MST;
      last_owner_q   <= ~DEF_MST;
    end else if (HREADY) begin
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_q;
      last_owner_q   <= last_owner_d;
    end
  end

  assign HMASTER      = hmaster_q;
  assign HMASTER_DATA = hmaster_data_q;
  assign grant_cpu    = (hmaster_q == MST_CPU);
  assign grant_dma    = (hmaster_q == MST_DMA);
  assign HMASTLOCK    = owner_lock;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - scoreboard bench for the CPU/DMA AHB arbiter
module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  localparam logic [1:0] TI = HTRANS_IDLE;
  localparam logic [1:0] TN = HTRANS_NONSEQ;
  localparam logic [1:0] TS = HTRANS_SEQ;
  localparam logic [2:0] BS = HBURST_SINGLE;
  localparam logic [2:0] BI = HBURST_INCR;
  localparam logic [2:0] B4 = HBURST_INCR4;
  localparam logic [2:0] W8 = HBURST_WRAP8;
  localparam logic [2:0] B8 = HBURST_INCR8;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic req_cpu = 1'b0, req_dma = 1'b0, lock_cpu = 1'b0, lock_dma = 1'b0;
  logic [1:0] HTRANS = 2'b00;
  logic [2:0] HBURST = 3'b000;
  logic HREADY = 1'b1, HRESP = 1'b0;
  logic HMASTER, HMASTER_DATA, grant_cpu, grant_dma, HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.MAX_HOLD(4), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_cpu(req_cpu), .req_dma(req_dma),
    .lock_cpu(lock_cpu), .lock_dma(lock_dma), .HTRANS(HTRANS), .HBURST(HBURST),
    .HREADY(HREADY), .HRESP(HRESP), .HMASTER(HMASTER), .HMASTER_DATA(HMASTER_DATA),
    .grant_cpu(grant_cpu), .grant_dma(grant_dma), .HMASTLOCK(HMASTLOCK)
  );

  typedef struct {
    string      name;
    logic       m;
    logic       d;
    logic       lk;
    logic       bchk;
    logic [4:0] bl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic [1:0] tr, input logic [2:0] bu,
                      input logic rc, input logic rd, input logic lc, input logic ld,
                      input logic rdy, input logic rsp, input logic em, input logic ed,
                      input logic bchk, input logic [4:0] bl);
    exp_t e;
    @(posedge HCLK);
    #2;
    HTRANS = tr; HBURST = bu; req_cpu = rc; req_dma = rd;
    lock_cpu = lc; lock_dma = ld; HREADY = rdy; HRESP = rsp;
    e.name = nm; e.m = em; e.d = ed; e.lk = em ? ld : lc; e.bchk = bchk; e.bl = bl;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.name, ".hmaster"}, 5'(HMASTER), 5'(e.m));
        chk({e.name, ".hmaster_data"}, 5'(HMASTER_DATA), 5'(e.d));
        chk({e.name, ".grants"}, {3'b0, grant_dma, grant_cpu}, {3'b0, e.m, ~e.m});
        chk({e.name, ".hmastlock"}, 5'(HMASTLOCK), 5'(e.lk));
        if (e.bchk) chk({e.name, ".beats_left"}, dut.u_tracker.beats_left_q, e.bl);
      end
    end
  end

  initial begin : stim
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst.hmaster", 5'(HMASTER), 5'd0);
    chk("rst.hmaster_data", 5'(HMASTER_DATA), 5'd0);
    chk("rst.grant_cpu", 5'(grant_cpu), 5'd1);
    #1 HRESETn = 1'b1;

    // Idle, nobody requests: parked on CPU
    for (int i = 0; i < 10; i++) step("idle", TI, BS, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'd0);

    // CPU INCR4, DMA joins at beat 2, handover on the beat-4 edge
    step("incr4_b1", TN, B4, 1, 0, 0, 0, 1, 0, 0, 0, 1, 5'd3);
    step("incr4_b2", TS, B4, 1, 1, 0, 0, 1, 0, 0, 0, 1, 5'd2);
    step("incr4_b3", TS, B4, 1, 1, 0, 0, 1, 0, 0, 0, 1, 5'd1);
    step("incr4_b4", TS, B4, 1, 1, 0, 0, 1, 0, 1, 0, 1, 5'd0);
    step("incr4_dma", TI, BS, 0, 1, 0, 0, 1, 0, 1, 1, 1, 5'd0);
    step("incr4_park", TI, BS, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd0);
    step("incr4_idle", TI, BS, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'd0);

    // Both request SINGLEs: strict alternation
    step("rr_1", TN, BS, 1, 1, 0, 0, 1, 0, 1, 0, 0, 5'd0);
    step("rr_2", TN, BS, 1, 1, 0, 0, 1, 0, 0, 1, 0, 5'd0);
    step("rr_3", TN, BS, 1, 1, 0, 0, 1, 0, 1, 0, 0, 5'd0);
    step("rr_4", TN, BS, 1, 1, 0, 0, 1, 0, 0, 1, 0, 5'd0);
    step("rr_idle", TI, BS, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'd0);

    // CPU INCR with MAX_HOLD=4: exactly four beats before DMA takes over
    step("hold_1", TN, BI, 1, 1, 0, 0, 1, 0, 0, 0, 1, 5'd0);
    step("hold_2", TS, BI, 1, 1, 0, 0, 1, 0, 0, 0, 0, 5'd0);
    step("hold_3", TS, BI, 1, 1, 0, 0, 1, 0, 0, 0, 0, 5'd0);
    step("hold_4", TS, BI, 1, 1, 0, 0, 1, 0, 1, 0, 0, 5'd0);
    step("hold_park", TI, BS, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd0);
    step("hold_idle", TI, BS, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'd0);

    // DMA locked, its request drops, CPU waits; HREADY low freezes everything
    step("lock_get", TI, BS, 0, 1, 0, 1, 1, 0, 1, 0, 0, 5'd0);
    step("lock_ns", TN, BI, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd0);
    step("lock_seq", TS, BI, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd0);
    step("lock_idle", TI, BS, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd0);
    for (int i = 0; i < 3; i++) step("lock_wait", TI, BS, 1, 0, 0, 0, 0, 0, 1, 1, 0, 5'd0);
    step("lock_rel", TI, BS, 1, 0, 0, 0, 1, 0, 0, 1, 0, 5'd0);
    step("lock_cpu", TI, BS, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'd0);

    // ERROR on beat 2 of a DMA WRAP8 with the CPU requesting
    step("err_get", TI, BS, 0, 1, 0, 0, 1, 0, 1, 0, 1, 5'd0);
    step("err_ns", TN, W8, 1, 1, 0, 0, 1, 0, 1, 1, 1, 5'd7);
    step("err_1st", TS, W8, 1, 1, 0, 0, 0, 1, 1, 1, 1, 5'd7);
    step("err_2nd", TS, W8, 1, 0, 0, 0, 1, 1, 0, 1, 1, 5'd0);
    step("err_idle", TI, BS, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd0);

    // Reset asserted in the middle of a DMA INCR8
    step("mrst_get", TI, BS, 0, 1, 0, 0, 1, 0, 1, 0, 1, 5'd0);
    step("mrst_ns", TN, B8, 0, 1, 0, 0, 1, 0, 1, 1, 1, 5'd7);
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    chk("mrst.hmaster", 5'(HMASTER), 5'd0);
    chk("mrst.hmaster_data", 5'(HMASTER_DATA), 5'd0);
    chk("mrst.grants", {3'b0, grant_dma, grant_cpu}, 5'b00001);
    chk("mrst.beats_left", dut.u_tracker.beats_left_q, 5'd0);
    @(posedge HCLK);
    #2;
    HTRANS = TI; HBURST = BS; req_cpu = 0; req_dma = 0; lock_dma = 0; HREADY = 1; HRESP = 0;
    HRESETn = 1'b1;
    step("mrst_after", TI, BS, 1, 0, 0, 0, 1, 0, 0, 0, 1, 5'd0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge HCLK);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum address-phase beats one master holds the bus in an undefined-length (INCR) burst while the other master requests.
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0: master parked on when nobody requests (0 = CPU, 1 = DMA).
REQ-003 SHALL have ports, in this order:
- HCLK  in  1  single clock for the block.
- HRESETn  in  1  reset, asynchronous, active-low.
- req_cpu  in  1  CPU requests the bus (HTRANS_CPU[1]).
- req_dma  in  1  DMA requests the bus (HTRANS_DMA[1]).
- lock_cpu  in  1  CPU HMASTLOCK.
- lock_dma  in  1  DMA HMASTLOCK.
- HTRANS  in  2  muxed address-phase transfer type.
- HBURST  in  3  muxed burst type.
- HREADY  in  1  shared bus ready.
- HRESP  in  1  shared response; 1 = ERROR.
- HMASTER  out  1  address-phase owner; mux select for HADDR, HTRANS, HBURST, HSIZE, HPROT, HWRITE.
- HMASTER_DATA  out  1  data-phase owner; mux select for HWDATA, and routes HRDATA, HREADY and HRESP.
- grant_cpu  out  1  HMASTER == 0.
- grant_dma  out  1  HMASTER == 1.
- HMASTLOCK  out  1  combinational; lock input of the current HMASTER owner.

Function
REQ-004 SHALL keep the state registers HMASTER, HMASTER_DATA, last_owner, beats_left (5 bits) and hold_cnt (5 bits); all of them SHALL change only on a rising edge of HCLK where HREADY = 1.
REQ-005 SHALL load HMASTER_DATA <= HMASTER on every HREADY = 1 edge, giving a data-phase owner that lags HMASTER by exactly one completed address phase.
REQ-006 SHALL load beats_left on an address-phase NONSEQ accepted with HREADY = 1:
- INCR4 or WRAP4: 3.
- INCR8 or WRAP8: 7.
- INCR16 or WRAP16: 15.
- SINGLE or INCR: 0.
REQ-007 SHALL decrement beats_left on each accepted SEQ while beats_left > 0, and SHALL NOT change it on BUSY or IDLE.
REQ-008 SHALL increment hold_cnt on each accepted NONSEQ or SEQ, saturating at MAX_HOLD, and SHALL clear it whenever HMASTER changes.
REQ-009 SHALL treat an edge as an arbitration point only when all of the following hold:
- HREADY = 1.
- The owner's lock is 0.
- HTRANS != BUSY.
- One of these is true:
  - HTRANS = IDLE.
  - The accepted beat is the final beat of a fixed burst: NONSEQ SINGLE, or SEQ with beats_left = 1.
  - HBURST = INCR and hold_cnt >= MAX_HOLD - 1.
REQ-010 SHALL pick the next owner at an arbitration point as follows:
- Only one master requesting: that master.
- Both requesting: the master that is not last_owner (round-robin).
- Neither requesting: DEFAULT_MASTER.
REQ-011 SHALL set last_owner <= HMASTER whenever HMASTER changes.
REQ-012 SHALL NOT change HMASTER on any edge that is not an arbitration point, including while the owner's request is deasserted mid-burst.
REQ-013 SHALL treat HRESP = 1 with HREADY = 1 (second ERROR cycle) as follows:
- Clear beats_left to 0.
- Treat the edge as an arbitration point regardless of burst state, unless the owner's lock is 1.
REQ-014 SHALL NOT stall the bus: a handover takes zero dead cycles, so the new owner drives the address phase on the cycle after the arbitration point.
REQ-015 SHALL keep HMASTER unchanged, even if the owner's request is 0, while the owner's lock is 1, until lock falls and an arbitration point occurs.
REQ-016 SHALL resolve simultaneous request changes: when both requests rise on the same edge, round-robin applies; when the owner's request falls on the same edge the other request rises, the other master wins.
REQ-017 SHALL hold all state while HREADY = 0, whatever happens on the request inputs.

Reset
REQ-018 SHALL, while HRESETn = 0, asynchronously force:
- HMASTER = HMASTER_DATA = DEFAULT_MASTER.
- last_owner = the master other than DEFAULT_MASTER.
- beats_left = 0.
- hold_cnt = 0.
- grant outputs decoded from DEFAULT_MASTER.
REQ-019 SHALL drop any burst in progress when reset is asserted mid-burst, and on release SHALL restart from the REQ-018 values with no memory of the burst.

Structure
REQ-020 SHALL take the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), the HBURST encodings and the master IDs (MST_CPU = 0, MST_DMA = 1) from the shared package ahb_pkg.
REQ-021 SHALL put burst-length decode and the beats_left/hold_cnt counters in one sub-module, ahb_arb_burst_tracker, and keep next-owner selection in the top.

Verification
REQ-022 Reset, no requests: HMASTER = 0, grant_cpu = 1 and HMASTER_DATA = 0; all three stay unchanged after 10 cycles.
REQ-023 CPU INCR4 in progress, DMA requests at beat 2: HMASTER switches to 1 only on the edge accepting SEQ beat 4; HMASTER_DATA switches one HREADY edge later.
REQ-024 Both request continuously with SINGLE transfers: HMASTER alternates 0, 1, 0, 1 on consecutive accepted beats.
REQ-025 CPU INCR (undefined length) with MAX_HOLD = 4, DMA requesting: CPU keeps the bus for exactly 4 beats, then HMASTER = 1.
REQ-026 DMA locked (lock_dma = 1) with req_dma dropping and CPU requesting: HMASTER stays 1 until lock_dma = 0 and HTRANS = IDLE; HREADY = 0 for 3 cycles freezes HMASTER and HMASTER_DATA.
REQ-027 ERROR response on beat 2 of a DMA WRAP8 with the CPU requesting: beats_left = 0 and HMASTER = 0 on the next edge. HRESETn asserted mid-burst: outputs return to the REQ-018 values immediately, without waiting for a clock edge.
